xor_accumulator: RTL and testbench
==================================

XOR_ACCUMULATOR -- requirements
Module: xor_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter FRAME_LEN, default 4: maximum words per frame, legal range 1..255.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 Port in_valid, input, 1 bit: input word present.
REQ-006 Port in_ready, output, 1 bit: block accepts the input word this cycle.
REQ-007 Port in_data, input, WIDTH bits: input word.
REQ-008 Port in_last, input, 1 bit: the word is the last word of its frame.
REQ-009 Port out_valid, output, 1 bit: frame result available.
REQ-010 Port out_ready, input, 1 bit: consumer takes the result this cycle.
REQ-011 Port out_data, output, WIDTH bits: bitwise XOR of all words in the frame.
REQ-012 Port out_count, output, $clog2(FRAME_LEN+1) bits: number of words in the frame.

Function
REQ-013 An input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-014 The block SHALL have a two-state FSM: ACCUM (collecting words) and HOLD (result presented); reset state is ACCUM.
REQ-015 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; on each input transfer the accumulator SHALL become acc XOR in_data and the word count SHALL increment.
REQ-016 A frame SHALL close on the input transfer where in_last=1, or where the count reaches FRAME_LEN, whichever comes first.
REQ-017 On frame close, the FSM SHALL go to HOLD on the next edge, with out_data = XOR of all frame words, including the closing word, and out_count = word count; latency from closing transfer to out_valid SHALL be 1 cycle.
REQ-018 In HOLD, out_valid SHALL be 1, and out_data and out_count SHALL stay stable until the output transfer.
REQ-019 In HOLD, in_ready SHALL equal out_ready, so the input stalls while the output is backpressured.
REQ-020 An input transfer and an output transfer in the same HOLD cycle SHALL start the next frame with no bubble: acc = in_data, count = 1.
REQ-021 If a word accepted in that HOLD cycle also closes its frame (in_last=1 or FRAME_LEN=1), the FSM SHALL stay in HOLD and present the new result.
REQ-022 An output transfer with no input transfer SHALL clear acc and count to 0 and return the FSM to ACCUM.
REQ-023 When FRAME_LEN=1, every word SHALL form its own frame and out_count SHALL always be 1.
REQ-024 Arithmetic: the count SHALL never exceed FRAME_LEN; no wrap-around is permitted.

Reset
REQ-025 While rst_n=0: FSM = ACCUM, acc = 0, count = 0, out_valid = 0, out_data = 0, out_count = 0, in_ready = 0.
REQ-026 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts.
REQ-027 A reset mid-frame or during HOLD SHALL discard the partial or pending result without emitting it.

Configuration
REQ-028 With macro XOR_ACCUMULATOR_PARITY_EN defined, the block SHALL add output port out_parity (1 bit), equal to the XOR-reduction of out_data, valid with out_valid, and 0 in reset.
REQ-029 Without XOR_ACCUMULATOR_PARITY_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package xor_accumulator_pkg SHALL hold the FSM state enum typedef (ACCUM, HOLD) and the function for the count width.
REQ-031 The bitwise XOR SHALL be done in sub-module mux_xor_word (parameter WIDTH): per-bit XOR built only from 2:1 mux instances and the constants 0 and 1.
REQ-032 xor_accumulator SHALL instantiate mux_xor_word exactly once.

Verification
REQ-033 Scenario 1: WIDTH=8, FRAME_LEN=4; words 0x01, 0x02, 0x04, in_last on 0x08; out_ready=1 -> out_valid one cycle after the last word, out_data=0x0F, out_count=4.
REQ-034 Scenario 2: words 0xA5, then 0xA5 with in_last -> out_data=0x00, out_count=2.
REQ-035 Scenario 3: FRAME_LEN=4 with no in_last; six words 0x11..0x16 -> first result 0x11^0x12^0x13^0x14=0x04 with count 4; second frame stays open at count 2.
REQ-036 Scenario 4: out_ready=0 for 5 cycles in HOLD -> in_ready=0 and out_data stable; then out_ready=1 with in_valid=1 (0x33, in_last=0) -> output transfer plus input transfer in the same cycle, new frame acc=0x33.
REQ-037 Scenario 5: rst_n pulsed low after 2 of 4 words, asynchronously, mid-cycle -> outputs clear immediately, no result emitted; a next frame of 0xFF with in_last gives out_data=0xFF, out_count=1.
REQ-038 Scenario 6 (XOR_ACCUMULATOR_PARITY_EN): frame result 0x07 -> out_parity=1; result 0x03 -> out_parity=0.

Source files
------------

// File: rtl/xor_accumulator_pkg.sv
// Shared types and helpers for the XOR frame accumulator.
package xor_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int count_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/mux_xor_word.sv
// Word-wide XOR where each bit is two 2:1 mux cells fed by the constants 0/1.
module mux_xor_word #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic b_n;
    // First mux inverts b; second selects b or ~b depending on a.
    assign b_n  = b[i] ? 1'b0 : 1'b1;
    assign y[i] = a[i] ? b_n : b[i];
  end

endmodule

// File: rtl/xor_accumulator.sv
// Collects framed words and presents their XOR and word count with valid/ready.
// Optional out_parity port is enabled by defining XOR_ACCUMULATOR_PARITY_EN.
module xor_accumulator
  import xor_accumulator_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH-1:0]                    out_data,
  output logic [count_width(FRAME_LEN)-1:0]   out_count
`ifdef XOR_ACCUMULATOR_PARITY_EN
  ,
  output logic                                out_parity
`endif
);

  localparam int            CW      = count_width(FRAME_LEN);
  localparam logic [CW-1:0] LEN_MAX = CW'(FRAME_LEN);

  state_t          state;
  logic            run;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] xor_res;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            in_fire;
  logic            out_fire;
  logic            closes;

  mux_xor_word #(.WIDTH(WIDTH)) u_xor (
    .a (acc),
    .b (in_data),
    .y (xor_res)
  );

  // acc/cnt are zero while holding, so a word taken in HOLD starts a fresh frame.
  assign in_ready = run & ((state == ACCUM) | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign cnt_next = cnt + CW'(1);
  assign closes   = in_last | (cnt_next == LEN_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      run        <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
`ifdef XOR_ACCUMULATOR_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      run <= 1'b1;
      if (in_fire) begin
        if (closes) begin
          state      <= HOLD;
          out_valid  <= 1'b1;
          out_data   <= xor_res;
          out_count  <= cnt_next;
          acc        <= '0;
          cnt        <= '0;
`ifdef XOR_ACCUMULATOR_PARITY_EN
          out_parity <= ^xor_res;
`endif
        end else begin
          state     <= ACCUM;
          out_valid <= 1'b0;
          acc       <= xor_res;
          cnt       <= cnt_next;
        end
      end else if (out_fire) begin
        state     <= ACCUM;
        out_valid <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_xor_accumulator.sv
// Scoreboard bench for xor_accumulator: directed frames, monitor pops expected results.
module tb_xor_accumulator;

  localparam int W  = 8;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef XOR_ACCUMULATOR_PARITY_EN
  logic          out_parity;
`endif

  typedef struct packed {
    logic [W-1:0]  d;
    logic [CW-1:0] c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  xor_accumulator #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef XOR_ACCUMULATOR_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data %0h count %0d expected none at %0t",
                 out_data, out_count, $time);
      end else begin
        e = q.pop_front();
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_count", 64'(out_count), 64'(e.c));
`ifdef XOR_ACCUMULATOR_PARITY_EN
        check("out_parity", 64'(out_parity), 64'(^e.d));
`endif
      end
    end
  end

  task automatic push(input logic [W-1:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = CW'(c);
    q.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] d, input logic last);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 for word %0h", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: time %0t expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    #11 rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rel_in_ready_high", 64'(in_ready), 64'd1);

    // Frame closed by in_last
    out_ready = 1'b1;
    push(8'h0F, 4);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h04, 1'b0);
    check("pre_close_valid", 64'(out_valid), 64'd0);
    send(8'h08, 1'b1);
    check("latency_valid", 64'(out_valid), 64'd1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Self-cancelling pair
    push(8'h00, 2);
    send(8'hA5, 1'b0);
    send(8'hA5, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Frame closed by FRAME_LEN, second frame left open at 2 words
    push(8'h04, 4);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    send(8'h14, 1'b0);
    send(8'h15, 1'b0);
    send(8'h16, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("open_frame_valid", 64'(out_valid), 64'd0);
    push(8'h14, 3);
    send(8'h17, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Backpressure in HOLD, then simultaneous output and input transfer
    out_ready = 1'b0;
    push(8'h07, 3);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h04, 1'b1);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_out_data", 64'(out_data), 64'h07);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h33, 1'b0);
    check("restart_valid", 64'(out_valid), 64'd0);
    push(8'h30, 2);
    send(8'h03, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Result with even parity
    push(8'h03, 2);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Frame closing inside HOLD stays in HOLD
    push(8'h0A, 1);
    push(8'h0B, 1);
    send(8'h0A, 1'b1);
    send(8'h0B, 1'b1);
    check("hold_chain_valid", 64'(out_valid), 64'd1);
    check("hold_chain_data", 64'(out_data), 64'h0B);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-frame discards the partial frame
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    idle();
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_out_count", 64'(out_count), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    push(8'hFF, 1);
    send(8'hFF, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
